servo_move_sched: RTL and testbench
===================================

# servo_move_sched

Motion scheduler for the servo PWM channel. Up to four requesters ask to move the servo to a target pulse width. The block arbitrates them round-robin and slews the active pulse width toward the granted target by a bounded step per 20 ms frame. It also generates the PWM waveform, so a width change only ever takes effect on a frame boundary. It sits between user-facing logic (switch/jog handlers, preset sequencers) and the servo output pin.

## Interface

Parameters:
- FRAME_CYC, 2_000_000: frame period in clk cycles (20 ms at 100 MHz).
- PW_MIN, 50_000: minimum pulse width in cycles (0.5 ms, 0°).
- PW_MAX, 240_000: maximum pulse width in cycles (2.4 ms, 180°).
- PW_INIT, 50_000: pulse width after reset.
- STEP, 1_000: maximum pulse-width change per frame, in cycles.

Ports:
- clk  in  1: single system clock; all logic on its rising edge.
- rst_n  in  1: reset, asynchronous and active-low.
- req  in  4: per-requester move request, level; held until done or abort.
- tgt  in  72: four 18-bit targets; requester i uses bits [18i+17:18i]; must be stable while req[i] is high.
- gnt  out  4: one-hot grant; identifies the requester owning the servo.
- done  out  4: one-cycle pulse to the granted requester when the target is reached.
- busy  out  1: high in any state other than IDLE.
- pw  out  18: pulse width currently applied, in cycles.
- frame_tick  out  1: high for one cycle on the last cycle of each frame.
- pwm  out  1: servo drive signal.

## Operation

- Reset (async, rst_n=0) sets: state IDLE, rr_ptr=0, frame_cnt=0, pw=PW_INIT, gnt=0, done=0, busy=0, frame_tick=0, pwm=0. Reset taken mid-move discards the move with no done; pw returns to PW_INIT.
- Frame counter:
  - frame_cnt (21 bits) counts 0..FRAME_CYC-1 and wraps to 0.
  - frame_tick is asserted when frame_cnt==FRAME_CYC-1.
- PWM:
  - pwm is registered: pwm <= (frame_cnt < pw).
  - pwm is therefore high for exactly pw cycles per frame, delayed one cycle from frame_cnt.
- Target latch:
  - On grant, tgt slice i is latched into tgt_r and clamped: values below PW_MIN become PW_MIN; values above PW_MAX become PW_MAX.
  - Changes to tgt after the grant are ignored.
- State machine:
  - IDLE: if req != 0, select the first set bit at or after rr_ptr, wrapping modulo 4. Set gnt one-hot, latch tgt_r, set rr_ptr = index+1 mod 4, go to MOVE.
  - MOVE: on frame_tick, pw steps toward tgt_r: pw <= pw ± min(STEP, |tgt_r - pw|), with no change if pw==tgt_r. If the new pw equals tgt_r, go to DONE.
  - MOVE abort: if req[gnt index] drops while in MOVE, clear gnt and return to IDLE with no done pulse. pw keeps its current value. Abort takes priority over a frame_tick in the same cycle, so no step is taken.
  - DONE: done[index] is high for only the first cycle in DONE. gnt is held until req[index]==0, then gnt is cleared and the state returns to IDLE.
- pw changes only on frame_tick cycles (and on reset), so every frame carries a single constant width.
- Arithmetic: |tgt_r - pw| is computed in 18 bits unsigned, comparing before subtracting. pw never leaves [PW_MIN, PW_MAX] after its first clamped target.

## Timing

- req[i] first seen high in IDLE at cycle N: gnt[i]=1 and busy=1 at N+1.
- A move of distance D completes after ceil(D/STEP) frame_ticks.
  - Special case D=0: the move completes at the first frame_tick.
- done asserts the cycle after the final stepping frame_tick, in the same cycle the new pw becomes visible to pwm.
- A requester deasserting req in cycle M while in DONE: gnt=0 and busy=0 at M+1. A new grant is possible at M+2.
- Simultaneous requests: exactly one grant. The others wait in IDLE order per rr_ptr. No requester waits more than 3 other moves.

## Test plan

Bench parameters: FRAME_CYC=2000, PW_MIN=500, PW_MAX=1500, PW_INIT=500, STEP=100.

- Reset: pulse rst_n low mid-frame -> every output at its reset value, pw=500. In the next frame, pwm is high for exactly 500 cycles.
- Single move: req[0]=1, tgt0=1000 -> gnt=0001 next cycle; pw goes 600, 700 … 1000 on 5 successive frame_ticks; done[0] pulses once; drop req[0] -> busy=0.
- Clamp and downward move: tgt2=5000 gives final pw=1500 after 10 ticks; then tgt2=0 ramps back to 500 with done[2].
- Round-robin: req=1011 held, each requester dropping req after its done -> grant order 0, 1, 3. Then re-raise req0 and req1 together with rr_ptr=0 -> requester 0 granted first.
- Abort: drop req[1] after 3 ticks of a 500→1200 move -> no done, gnt=0, pw=800 held across subsequent frames.
- Boundary cases:
  - tgt equal to current pw -> done after the first frame_tick.
  - Residual distance 50 < STEP -> final step is exactly 50.
  - Abort coinciding with frame_tick -> no step taken.

Source files
------------

// File: rtl/servo_move_sched.sv
// rtl/servo_move_sched.sv - round-robin servo move scheduler with frame-aligned PWM
// Slews the applied pulse width toward the granted target by at most STEP per frame.
module servo_move_sched #(
  parameter int unsigned FRAME_CYC = 2_000_000,
  parameter int unsigned PW_MIN    = 50_000,
  parameter int unsigned PW_MAX    = 240_000,
  parameter int unsigned PW_INIT   = 50_000,
  parameter int unsigned STEP      = 1_000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [3:0]  req,
  input  logic [71:0] tgt,
  output logic [3:0]  gnt,
  output logic [3:0]  done,
  output logic        busy,
  output logic [17:0] pw,
  output logic        frame_tick,
  output logic        pwm
);

  localparam logic [17:0] LP_MIN  = 18'(PW_MIN);
  localparam logic [17:0] LP_MAX  = 18'(PW_MAX);
  localparam logic [17:0] LP_INIT = 18'(PW_INIT);
  localparam logic [17:0] LP_STEP = 18'(STEP);
  localparam logic [20:0] LP_LAST = 21'(FRAME_CYC - 1);

  typedef enum logic [1:0] {S_IDLE, S_MOVE, S_DONE} state_t;

  state_t      r_state;
  logic [20:0] r_frame_cnt;
  logic [1:0]  r_rr_ptr;
  logic [1:0]  r_idx;
  logic [17:0] r_pw;
  logic [17:0] r_tgt;
  logic [3:0]  r_gnt;
  logic [3:0]  r_done;
  logic        r_pwm;

  logic        w_tick;
  logic [1:0]  w_sel;
  logic [17:0] w_tgt_raw;
  logic [17:0] w_tgt_clamp;
  logic        w_up;
  logic [17:0] w_diff;
  logic [17:0] w_step;
  logic [17:0] w_pw_next;
  logic        w_req_held;

  assign w_tick = (r_frame_cnt == LP_LAST);

  // Scan downward so the last hit is the first set bit at or after r_rr_ptr.
  always_comb begin
    w_sel = r_rr_ptr;
    for (int k = 3; k >= 0; k--) begin
      if (req[2'(r_rr_ptr + 2'(k))]) begin
        w_sel = 2'(r_rr_ptr + 2'(k));
      end
    end
  end

  always_comb begin
    w_tgt_raw = tgt[17:0];
    case (w_sel)
      2'd0:    w_tgt_raw = tgt[17:0];
      2'd1:    w_tgt_raw = tgt[35:18];
      2'd2:    w_tgt_raw = tgt[53:36];
      default: w_tgt_raw = tgt[71:54];
    endcase
    if (w_tgt_raw < LP_MIN) begin
      w_tgt_clamp = LP_MIN;
    end else if (w_tgt_raw > LP_MAX) begin
      w_tgt_clamp = LP_MAX;
    end else begin
      w_tgt_clamp = w_tgt_raw;
    end
  end

  // Compare before subtracting so the 18-bit distance never wraps.
  always_comb begin
    w_up      = (r_tgt > r_pw);
    w_diff    = w_up ? (r_tgt - r_pw) : (r_pw - r_tgt);
    w_step    = (w_diff < LP_STEP) ? w_diff : LP_STEP;
    w_pw_next = w_up ? (r_pw + w_step) : (r_pw - w_step);
  end

  assign w_req_held = req[r_idx];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_frame_cnt <= '0;
      r_pwm       <= 1'b0;
    end else begin
      r_frame_cnt <= w_tick ? '0 : r_frame_cnt + 21'd1;
      r_pwm       <= ({3'b000, r_pw} > r_frame_cnt);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= S_IDLE;
      r_rr_ptr <= '0;
      r_idx    <= '0;
      r_pw     <= LP_INIT;
      r_tgt    <= LP_INIT;
      r_gnt    <= '0;
      r_done   <= '0;
    end else begin
      r_done <= '0;
      case (r_state)
        S_IDLE: begin
          if (|req) begin
            r_gnt    <= 4'b0001 << w_sel;
            r_idx    <= w_sel;
            r_rr_ptr <= w_sel + 2'd1;
            r_tgt    <= w_tgt_clamp;
            r_state  <= S_MOVE;
          end
        end
        S_MOVE: begin
          // A dropped request wins over a coincident frame tick: no step.
          if (!w_req_held) begin
            r_gnt   <= '0;
            r_state <= S_IDLE;
          end else if (w_tick) begin
            r_pw <= w_pw_next;
            if (w_pw_next == r_tgt) begin
              r_done  <= r_gnt;
              r_state <= S_DONE;
            end
          end
        end
        S_DONE: begin
          if (!w_req_held) begin
            r_gnt   <= '0;
            r_state <= S_IDLE;
          end
        end
        default: begin
          r_gnt   <= '0;
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign gnt        = r_gnt;
  assign done       = r_done;
  assign busy       = (r_state != S_IDLE);
  assign pw         = r_pw;
  assign frame_tick = w_tick;
  assign pwm        = r_pwm;

endmodule

// File: tb/tb_servo_move_sched.sv
// tb/tb_servo_move_sched.sv - scoreboard bench for servo_move_sched
// Expected pw steps and done pulses are queued at grant time and popped by a monitor.
module tb_servo_move_sched;

  localparam int FRAME = 2000;
  localparam int PMIN  = 500;
  localparam int PMAX  = 1500;
  localparam int PINIT = 500;
  localparam int STEPV = 100;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [3:0]  req = '0;
  logic [71:0] tgt = '0;
  logic [3:0]  gnt;
  logic [3:0]  done;
  logic        busy;
  logic [17:0] pw;
  logic        frame_tick;
  logic        pwm;

  always #5 clk = ~clk;

  servo_move_sched #(
    .FRAME_CYC (FRAME),
    .PW_MIN    (PMIN),
    .PW_MAX    (PMAX),
    .PW_INIT   (PINIT),
    .STEP      (STEPV)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req        (req),
    .tgt        (tgt),
    .gnt        (gnt),
    .done       (done),
    .busy       (busy),
    .pw         (pw),
    .frame_tick (frame_tick),
    .pwm        (pwm)
  );

  int n_checks = 0;
  int n_errors = 0;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, act, exp);
    end
  endtask

  int         exp_pw_q[$];
  logic [3:0] exp_done_q[$];
  int         m_pw = PINIT;
  int         tgt_of[4];
  int         last_pw = PINIT;
  bit         tick_prev = 1'b0;

  always @(negedge clk) begin
    if (!rst_n) begin
      last_pw = PINIT;
    end else begin
      if (int'(pw) != last_pw) begin
        chk("pw_on_tick", 32'(tick_prev), 1);
        if (exp_pw_q.size() == 0) chk("pw_unexp", pw, last_pw);
        else chk("pw_step", pw, exp_pw_q.pop_front());
        last_pw = int'(pw);
      end
      if (done != 4'b0) begin
        if (exp_done_q.size() == 0) chk("done_unexp", done, 0);
        else chk("done_val", done, exp_done_q.pop_front());
      end
    end
    tick_prev = (frame_tick === 1'b1);
  end

  function automatic int clampv(input int t);
    return (t < PMIN) ? PMIN : ((t > PMAX) ? PMAX : t);
  endfunction

  function automatic int ticks_for(input int from, input int to);
    int d;
    d = (to > from) ? to - from : from - to;
    return (d == 0) ? 1 : (d + STEPV - 1) / STEPV;
  endfunction

  task automatic push_steps(input int to, input int max_ticks);
    int p;
    p = m_pw;
    for (int k = 0; k < max_ticks && p != to; k++) begin
      if (to > p) p += ((to - p) < STEPV) ? (to - p) : STEPV;
      else        p -= ((p - to) < STEPV) ? (p - to) : STEPV;
      exp_pw_q.push_back(p);
    end
    m_pw = p;
  endtask

  task automatic tick_wait();
    int n;
    n = 0;
    while (frame_tick !== 1'b1 && n < 2 * FRAME) begin
      @(posedge clk); #1;
      n++;
    end
    if (frame_tick !== 1'b1) chk("tick_timeout", 0, 1);
  endtask

  task automatic set_tgt(input int idx, input int v);
    tgt[18*idx +: 18] = 18'(v);
  endtask

  task automatic raise(input int idx, input int v);
    tgt_of[idx] = v;
    set_tgt(idx, v);
    req[idx] = 1'b1;
  endtask

  task automatic check_reset(input string tag);
    chk({tag, "_gnt"}, gnt, 0);
    chk({tag, "_done"}, done, 0);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_pw"}, pw, PINIT);
    chk({tag, "_tick"}, frame_tick, 0);
    chk({tag, "_pwm"}, pwm, 0);
  endtask

  task automatic grant_and_finish(input int idx, input int tgt_late);
    int c;
    int n;
    @(posedge clk); #1;
    chk("gnt", gnt, 1 << idx);
    chk("busy", busy, 1);
    if (tgt_late >= 0) set_tgt(idx, tgt_late);
    c = clampv(tgt_of[idx]);
    n = ticks_for(m_pw, c);
    push_steps(c, n);
    exp_done_q.push_back(4'(1 << idx));
    for (int k = 0; k < n; k++) begin
      tick_wait();
      @(posedge clk); #1;
    end
    chk("done", done, 1 << idx);
    chk("pw_final", pw, c);
    req[idx] = 1'b0;
    @(posedge clk); #1;
    chk("gnt_clr", gnt, 0);
    chk("busy_clr", busy, 0);
  endtask

  initial begin
    int cnt;
    repeat (3) @(posedge clk);
    #1;
    check_reset("rst0");
    rst_n = 1'b1;
    repeat (700) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    check_reset("rst_mid");
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    m_pw = PINIT;

    tick_wait();
    cnt = 0;
    repeat (FRAME) begin
      @(posedge clk); #1;
      cnt += int'(pwm);
    end
    chk("pwm_high", cnt, 500);

    // clamp up, then clamp down with a late tgt change that must be ignored
    raise(2, 5000);
    grant_and_finish(2, -1);
    raise(2, 0);
    grant_and_finish(2, 1500);

    raise(0, 1000);
    grant_and_finish(0, -1);

    // reset in the middle of a move
    raise(3, 1500);
    @(posedge clk); #1;
    chk("gnt_mid", gnt, 4'b1000);
    push_steps(1500, 1);
    tick_wait();
    @(posedge clk); #1;
    chk("pw_mid", pw, 1100);
    repeat (300) @(posedge clk);
    #1;
    rst_n = 1'b0;
    req = '0;
    #1;
    check_reset("rst_move");
    exp_pw_q.delete();
    m_pw = PINIT;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;

    // round-robin from rr_ptr=0
    raise(0, 500);
    raise(1, 550);
    raise(3, 500);
    grant_and_finish(0, -1);
    grant_and_finish(1, -1);
    grant_and_finish(3, -1);
    raise(0, 500);
    raise(1, 500);
    grant_and_finish(0, -1);
    grant_and_finish(1, -1);

    // abort after three steps of 500 -> 1200
    raise(1, 1200);
    @(posedge clk); #1;
    chk("gnt_abort", gnt, 4'b0010);
    push_steps(1200, 3);
    for (int k = 0; k < 3; k++) begin
      tick_wait();
      @(posedge clk); #1;
    end
    chk("pw_abort", pw, 800);
    req[1] = 1'b0;
    @(posedge clk); #1;
    chk("gnt_abort_clr", gnt, 0);
    chk("busy_abort_clr", busy, 0);
    for (int k = 0; k < 2; k++) begin
      tick_wait();
      @(posedge clk); #1;
      chk("pw_hold", pw, 800);
    end

    // abort in the same cycle as frame_tick
    raise(2, 1500);
    @(posedge clk); #1;
    chk("gnt_tick_abort", gnt, 4'b0100);
    tick_wait();
    req[2] = 1'b0;
    @(posedge clk); #1;
    chk("gnt_tick_abort_clr", gnt, 0);
    chk("busy_tick_abort_clr", busy, 0);
    chk("pw_tick_abort", pw, 800);
    tick_wait();
    @(posedge clk); #1;
    chk("pw_tick_abort_hold", pw, 800);

    @(negedge clk);
    chk("done_q_empty", exp_done_q.size(), 0);
    chk("pw_q_empty", exp_pw_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
